// File: rtl/prim_sparse_fsm_checker.sv
// prim_sparse_fsm_checker
//   Reader side of a sparse-encoded FSM state register. Samples the raw state
//   vector, decodes it to a dense index, and flags illegal encodings through a
//   sticky fatal error plus a level req/ack alert handshake.
//
// Ports
//   clk_i        in   clock
//   rst_ni       in   synchronous active-low reset
//   state_i      in   [Width-1:0] raw sparse state from the state flop
//   idx_o        out  [IdxW-1:0]  dense index of the last legal state sampled
//   valid_o      out  state sampled last cycle was legal
//   err_o        out  sticky fatal error
//   alert_req_o  out  alert request, held until acknowledged
//   alert_ack_i  in   alert acknowledge from the alert sender
//   err_cnt_o    out  [7:0] total illegal samples, saturating at 8'hFF
module prim_sparse_fsm_checker #(
    parameter int unsigned                Width        = 6,
    parameter int unsigned                NumStates    = 4,
    parameter logic [NumStates*Width-1:0] ValidStates  = {6'b001101, 6'b110011,
                                                          6'b101001, 6'b010110},
    parameter int unsigned                ErrThreshold = 2,
    localparam int unsigned               IdxW         = (NumStates > 1) ? $clog2(NumStates) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] state_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o,
    output logic             err_o,
    output logic             alert_req_o,
    input  logic             alert_ack_i,
    output logic [7:0]       err_cnt_o
);

    localparam int unsigned RunW   = 4;
    localparam int unsigned CntW   = 8;
    localparam logic [RunW-1:0] RunMax = RunW'(ErrThreshold);
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    // Duplicate encodings would make the decode ambiguous.
    function automatic bit has_dup_entries();
        for (int unsigned i = 0; i < NumStates; i++) begin
            for (int unsigned j = i + 1; j < NumStates; j++) begin
                if (ValidStates[i*Width +: Width] == ValidStates[j*Width +: Width]) begin
                    return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    localparam bit DupEntries = has_dup_entries();

    if (DupEntries) begin : gen_dup_check
        $error("prim_sparse_fsm_checker: ValidStates contains duplicate encodings");
    end

    if (ErrThreshold < 1 || ErrThreshold > 15) begin : gen_thr_check
        $error("prim_sparse_fsm_checker: ErrThreshold must be within 1..15");
    end

    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_ALERT = 2'b01,
        ST_LOCK  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            err_d, req_d;
    logic            match;
    logic [IdxW-1:0] match_idx;
    logic [RunW-1:0] run_cnt_q;
    logic            fatal;

    // Table lookup of the raw state against every legal encoding.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int unsigned k = 0; k < NumStates; k++) begin
            if (state_i == ValidStates[k*Width +: Width]) begin
                match     = 1'b1;
                match_idx = IdxW'(k);
            end
        end
    end

    // Fatal is judged on the registered run length, so a single glitch never trips it.
    assign fatal = (run_cnt_q >= RunMax);

    // Alert FSM next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        req_d   = 1'b0;
        unique case (state_q)
            ST_OK: begin
                if (fatal) state_d = ST_ALERT;
            end
            ST_ALERT: begin
                if (alert_ack_i) state_d = ST_LOCK;
            end
            ST_LOCK: begin
                state_d = ST_LOCK;
            end
            // Unused encoding: fail safe into the locked error state.
            default: state_d = ST_LOCK;
        endcase
        err_d = (state_d != ST_OK);
        req_d = (state_d == ST_ALERT);
    end

    // FSM state register with registered err/req.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_OK;
            err_o       <= 1'b0;
            alert_req_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_o       <= err_d;
            alert_req_o <= req_d;
        end
    end

    // Decode outputs; index holds across illegal samples.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= match;
            if (match) idx_o <= match_idx;
        end
    end

    // Consecutive-illegal run counter and saturating total illegal count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            run_cnt_q <= '0;
            err_cnt_o <= '0;
        end else begin
            if (match) begin
                run_cnt_q <= '0;
            end else begin
                if (run_cnt_q < RunMax) run_cnt_q <= run_cnt_q + RunW'(1);
                if (err_cnt_o != CntMax) err_cnt_o <= err_cnt_o + CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_prim_sparse_fsm_checker.sv
// Testbench for prim_sparse_fsm_checker: directed scenarios plus random
// stimulus, checked through an expectation queue fed by a reference model.
module tb_prim_sparse_fsm_checker;

    localparam int THR = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] st;
    logic       ack;
    logic [1:0] idx;
    logic       valid, err, req;
    logic [7:0] cnt;

    always #5 clk = ~clk;

    prim_sparse_fsm_checker dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .state_i     (st),
        .idx_o       (idx),
        .valid_o     (valid),
        .err_o       (err),
        .alert_req_o (req),
        .alert_ack_i (ack),
        .err_cnt_o   (cnt)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic       valid;
        logic       err;
        logic       req;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [5:0] tbl [4] = '{6'b010110, 6'b101001, 6'b110011, 6'b001101};
    int         legal_idx [logic [5:0]];

    // Reference model state, expressed in terms of observed history.
    int m_idx, m_valid, m_err, m_req, m_cnt, m_streak;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_valid = 0; m_err = 0; m_req = 0; m_cnt = 0; m_streak = 0;
    endtask

    // One clock edge of the intended behaviour.
    task automatic model_edge(input logic [5:0] s, input logic a, input logic r);
        if (!r) begin
            model_reset();
        end else begin
            if (!m_err && m_streak >= THR) begin
                m_err = 1; m_req = 1;
            end else if (m_req && a) begin
                m_req = 0;
            end
            if (legal_idx.exists(s)) begin
                m_valid = 1; m_idx = legal_idx[s]; m_streak = 0;
            end else begin
                m_valid = 0; m_streak++;
                if (m_cnt < 255) m_cnt++;
            end
        end
    endtask

    // Drive one cycle: inputs at negedge, model at posedge, return at negedge.
    task automatic step(input logic [5:0] s, input logic a, input logic r);
        exp_t e;
        st = s; ack = a; rst_n = r;
        @(posedge clk);
        model_edge(s, a, r);
        e.idx = 2'(m_idx); e.valid = 1'(m_valid); e.err = 1'(m_err);
        e.req = 1'(m_req); e.cnt = 8'(m_cnt);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare DUT outputs against queued expectations each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_idx",   32'(idx),   32'(e.idx));
                chk("sb_valid", 32'(valid), 32'(e.valid));
                chk("sb_err",   32'(err),   32'(e.err));
                chk("sb_req",   32'(req),   32'(e.req));
                chk("sb_cnt",   32'(cnt),   32'(e.cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] s;
        logic       a, r;
        for (int k = 0; k < 4; k++) legal_idx[tbl[k]] = k;
        model_reset();
        st = '0; ack = 1'b0; rst_n = 1'b0;
        @(negedge clk);

        // T1 reset with an illegal input present
        repeat (3) step(6'b111111, 1'b0, 1'b0);
        chk("t1_valid", 32'(valid), 0);
        chk("t1_err",   32'(err),   0);
        chk("t1_req",   32'(req),   0);
        chk("t1_cnt",   32'(cnt),   0);
        chk("t1_idx",   32'(idx),   0);

        // T2 decode every entry
        for (int k = 0; k < 4; k++) step(tbl[k], 1'b0, 1'b1);
        chk("t2_idx3",   32'(idx),   3);
        chk("t2_valid3", 32'(valid), 1);

        // T3 single-cycle glitch
        step(6'b000000, 1'b0, 1'b1);
        chk("t3_glitch_valid", 32'(valid), 0);
        step(6'b101001, 1'b0, 1'b1);
        chk("t3_err", 32'(err), 0);
        chk("t3_cnt", 32'(cnt), 1);
        chk("t3_idx", 32'(idx), 1);
        step(6'b101001, 1'b0, 1'b1);
        chk("t3_err_late", 32'(err), 0);

        // T4 fatal handshake
        step(6'b000000, 1'b0, 1'b1);
        step(6'b000000, 1'b0, 1'b1);
        chk("t4_req_not_yet", 32'(req), 0);
        step(tbl[2], 1'b0, 1'b1);
        chk("t4_req", 32'(req), 1);
        chk("t4_err", 32'(err), 1);
        repeat (3) step(tbl[2], 1'b0, 1'b1);
        chk("t4_req_held", 32'(req), 1);
        step(tbl[2], 1'b1, 1'b1);
        chk("t4_req_acked", 32'(req), 0);
        chk("t4_err_sticky", 32'(err), 1);
        step(tbl[0], 1'b0, 1'b1);
        chk("t4_err_after_legal", 32'(err), 1);
        step(6'b000000, 1'b0, 1'b1);
        step(6'b000000, 1'b0, 1'b1);
        step(6'b000000, 1'b0, 1'b1);
        chk("t4_lock_no_req", 32'(req), 0);

        // T5 saturation
        repeat (300) step(6'b000000, 1'b0, 1'b1);
        chk("t5_cnt_sat", 32'(cnt), 8'hFF);
        repeat (5) step(6'b111111, 1'b0, 1'b1);
        chk("t5_cnt_hold", 32'(cnt), 8'hFF);

        // T6 reset while alert outstanding
        step(tbl[1], 1'b0, 1'b0);
        repeat (3) step(6'b000000, 1'b0, 1'b1);
        chk("t6_in_alert", 32'(req), 1);
        step(6'b000000, 1'b0, 1'b0);
        chk("t6_req", 32'(req), 0);
        chk("t6_err", 32'(err), 0);
        chk("t6_cnt", 32'(cnt), 0);
        chk("t6_valid", 32'(valid), 0);
        step(tbl[2], 1'b0, 1'b1);
        chk("t6_decode_valid", 32'(valid), 1);
        chk("t6_decode_idx", 32'(idx), 2);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 9) < 6) s = tbl[$urandom_range(0, 3)];
            else s = 6'($urandom);
            a = ($urandom_range(0, 3) == 0);
            step(s, a, r);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
